// File: rtl/sum_responder_pkg.sv
// Shared types and default sizing for the sum responder and its response buffer.
package sum_responder_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic {
    TAG_A = 1'b0,
    TAG_B = 1'b1
  } tag_e;

  // Width-independent part of a buffered response; ret is carried alongside it.
  typedef struct packed {
    tag_e tag;
    logic ovf;
  } resp_meta_t;

endpackage

// File: rtl/sum_resp_fifo.sv
// Response buffer: power-of-two FIFO, write visible on the read side one cycle after push.
// Push is ignored when full and pop when empty; count tracks simultaneous push/pop.
module sum_resp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/sum_responder.sv
// Two-port adder with round-robin call arbitration and an in-order response buffer (latency 1).
// Callers stall while the buffer is full; SUM_RESPONDER_SAT_EN saturates ret on carry out.
module sum_responder
  import sum_responder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [WIDTH-1:0]       a_arg1,
  input  logic [WIDTH-1:0]       a_arg2,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [WIDTH-1:0]       b_arg1,
  input  logic [WIDTH-1:0]       b_arg2,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WIDTH-1:0]       resp_ret,
  output logic                   resp_tag,
  output logic                   resp_ovf,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int EW = WIDTH + $bits(resp_meta_t);

  tag_e             last_grant_q, last_grant_d;
  logic             grant_a, grant_b, accept;
  logic             full, empty, pop;
  logic [WIDTH-1:0] op1, op2, ret, head_ret;
  logic [WIDTH:0]   sum;
  resp_meta_t       meta_in, meta_out;
  logic [EW-1:0]    push_dat, head_dat;

  always_comb begin
    grant_a = a_valid & (~b_valid | (last_grant_q == TAG_B));
    grant_b = b_valid & (~a_valid | (last_grant_q == TAG_A));
  end

  // rst_n gating keeps both readies low for the whole reset window.
  assign a_ready = grant_a & ~full & rst_n;
  assign b_ready = grant_b & ~full & rst_n;
  assign accept  = (a_valid & a_ready) | (b_valid & b_ready);

  always_comb begin
    op1 = b_ready ? b_arg1 : a_arg1;
    op2 = b_ready ? b_arg2 : a_arg2;
    sum = {1'b0, op1} + {1'b0, op2};
`ifdef SUM_RESPONDER_SAT_EN
    ret = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
    ret = sum[WIDTH-1:0];
`endif
    meta_in     = '0;
    meta_in.tag = b_ready ? TAG_B : TAG_A;
    meta_in.ovf = sum[WIDTH];
    push_dat    = {ret, meta_in};
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) begin
      last_grant_d = meta_in.tag;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= TAG_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  sum_resp_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (rst_n),
    .push_i  (accept),
    .din_i   (push_dat),
    .pop_i   (pop),
    .dout_o  (head_dat),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occupancy)
  );

  assign {head_ret, meta_out} = head_dat;

  assign resp_valid = ~empty;
  assign pop        = resp_valid & resp_ready;
  assign resp_ret   = resp_valid ? head_ret : '0;
  assign resp_tag   = resp_valid & (meta_out.tag == TAG_B);
  assign resp_ovf   = resp_valid & meta_out.ovf;

endmodule

// File: tb/tb_sum_responder.sv
// Directed bench for sum_responder at WIDTH=8, DEPTH=4; honours SUM_RESPONDER_SAT_EN.
module tb_sum_responder;

  logic       clock;
  logic       rst_n;
  logic       a_valid, a_ready, b_valid, b_ready;
  logic [7:0] a_arg1, a_arg2, b_arg1, b_arg2;
  logic       resp_valid, resp_ready, resp_tag, resp_ovf;
  logic [7:0] resp_ret;
  logic [2:0] occupancy;

  int vectors;
  int miscompares;

  logic [7:0] q_ret[$];
  logic       q_tag[$];
  int         sent;
  logic       rr, acc_exp, pop_exp;
  logic [7:0] ovf_exp;

  sum_responder #(.WIDTH(8), .DEPTH(4)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_arg1     (a_arg1),
    .a_arg2     (a_arg2),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_arg1     (b_arg1),
    .b_arg2     (b_arg2),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_ret   (resp_ret),
    .resp_tag   (resp_tag),
    .resp_ovf   (resp_ovf),
    .occupancy  (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
`ifdef SUM_RESPONDER_SAT_EN
    ovf_exp = 8'd255;
`else
    ovf_exp = 8'd44;
`endif
    rst_n = 1'b0;
    a_valid = 1'b1; a_arg1 = 8'd0; a_arg2 = 8'd0;
    b_valid = 1'b0; b_arg1 = 8'd0; b_arg2 = 8'd0;
    resp_ready = 1'b0;

    // Reset state, with a_valid held high to prove ready is forced low
    #2;
    chk("rst_occ", occupancy, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_ret", resp_ret, 0);
    chk("rst_tag", resp_tag, 0);
    chk("rst_ovf", resp_ovf, 0);
    chk("rst_a_ready", a_ready, 0);

    // Tie on both ports, released together with reset: A first, then B
    @(negedge clock);
    rst_n = 1'b1;
    a_valid = 1'b1; a_arg1 = 8'd3; a_arg2 = 8'd4;
    b_valid = 1'b1; b_arg1 = 8'd5; b_arg2 = 8'd6;
    #1;
    chk("tie1_a_ready", a_ready, 1);
    chk("tie1_b_ready", b_ready, 0);
    @(negedge clock); #1;
    chk("tie2_a_ready", a_ready, 0);
    chk("tie2_b_ready", b_ready, 1);
    chk("tie2_occ", occupancy, 1);
    @(negedge clock);
    a_valid = 1'b0; b_valid = 1'b0; resp_ready = 1'b1;
    #1;
    chk("tie_occ", occupancy, 2);
    chk("tie_ret0", resp_ret, 7);
    chk("tie_tag0", resp_tag, 0);
    @(negedge clock); #1;
    chk("tie_ret1", resp_ret, 11);
    chk("tie_tag1", resp_tag, 1);
    @(negedge clock); #1;
    chk("tie_empty_valid", resp_valid, 0);
    chk("tie_empty_occ", occupancy, 0);

    // Single A call 1+2, popped immediately
    @(negedge clock);
    a_valid = 1'b1; a_arg1 = 8'd1; a_arg2 = 8'd2;
    #1;
    chk("one_a_ready", a_ready, 1);
    @(negedge clock);
    a_valid = 1'b0;
    #1;
    chk("one_valid", resp_valid, 1);
    chk("one_ret", resp_ret, 3);
    chk("one_tag", resp_tag, 0);
    chk("one_ovf", resp_ovf, 0);
    chk("one_occ", occupancy, 1);
    @(negedge clock); #1;
    chk("one_occ_after", occupancy, 0);
    chk("one_ret_idle", resp_ret, 0);

    // Carry out 200+100, held while resp_ready is low
    @(negedge clock);
    resp_ready = 1'b0;
    a_valid = 1'b1; a_arg1 = 8'd200; a_arg2 = 8'd100;
    @(negedge clock);
    a_valid = 1'b0;
    #1;
    chk("ovf_flag", resp_ovf, 1);
    chk("ovf_ret", resp_ret, ovf_exp);
    @(negedge clock); #1;
    chk("ovf_hold_valid", resp_valid, 1);
    chk("ovf_hold_ret", resp_ret, ovf_exp);
    chk("ovf_hold_flag", resp_ovf, 1);
    resp_ready = 1'b1;
    @(negedge clock); #1;
    chk("ovf_drained", occupancy, 0);

    // Fill: five back-to-back A calls i+10 against a stalled return port
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      a_valid = 1'b1; a_arg1 = 8'(i); a_arg2 = 8'd10;
      #1;
      chk("fill_a_ready", a_ready, 1);
    end
    @(negedge clock);
    a_arg1 = 8'd4; a_arg2 = 8'd10;
    #1;
    chk("full_occ", occupancy, 4);
    chk("full_a_ready", a_ready, 0);
    chk("full_head", resp_ret, 10);
    resp_ready = 1'b1;
    @(negedge clock); #1;
    chk("drain_occ", occupancy, 3);
    chk("drain_a_ready", a_ready, 1);
    chk("drain_head", resp_ret, 11);
    @(negedge clock);
    a_valid = 1'b0;
    #1;
    chk("pushpop_occ", occupancy, 3);
    chk("drain_head2", resp_ret, 12);
    @(negedge clock); #1;
    chk("drain_head3", resp_ret, 13);
    @(negedge clock); #1;
    chk("drain_head4", resp_ret, 14);
    chk("drain_occ4", occupancy, 1);
    @(negedge clock); #1;
    chk("drain_done", resp_valid, 0);

    // Pointer wrap: 10 calls alternating ports, resp_ready toggling each cycle
    sent = 0;
    for (int cyc = 0; cyc < 80 && (sent < 10 || q_ret.size() > 0); cyc++) begin
      @(negedge clock);
      rr = cyc[0];
      resp_ready = rr;
      a_valid = 1'b0; b_valid = 1'b0;
      if (sent < 10) begin
        if (sent[0]) begin
          b_valid = 1'b1; b_arg1 = 8'(17 * sent + 3); b_arg2 = 8'(9 * sent);
        end else begin
          a_valid = 1'b1; a_arg1 = 8'(17 * sent + 3); a_arg2 = 8'(9 * sent);
        end
      end
      #1;
      chk("wrap_occ", occupancy, q_ret.size());
      chk("wrap_valid", resp_valid, q_ret.size() != 0);
      if (q_ret.size() != 0) begin
        chk("wrap_ret", resp_ret, q_ret[0]);
        chk("wrap_tag", resp_tag, q_tag[0]);
      end
      acc_exp = (sent < 10) && (q_ret.size() < 4);
      if (sent < 10) chk("wrap_ready", sent[0] ? b_ready : a_ready, acc_exp);
      pop_exp = rr && (q_ret.size() != 0);
      if (pop_exp) begin
        void'(q_ret.pop_front());
        void'(q_tag.pop_front());
      end
      if (acc_exp) begin
        q_ret.push_back(8'(26 * sent + 3));
        q_tag.push_back(sent[0]);
        sent++;
      end
    end
    chk("wrap_all_sent", sent, 10);
    chk("wrap_all_returned", q_ret.size(), 0);

    // Reset mid-operation with three responses buffered
    @(negedge clock);
    resp_ready = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      a_valid = 1'b1; a_arg1 = 8'd20; a_arg2 = 8'(i);
    end
    @(negedge clock);
    a_valid = 1'b0;
    #1;
    chk("mid_occ", occupancy, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_ret", resp_ret, 0);
    @(negedge clock);
    rst_n = 1'b1;
    a_valid = 1'b1; a_arg1 = 8'd1; a_arg2 = 8'd1;
    #1;
    chk("post_rst_a_ready", a_ready, 1);
    @(negedge clock);
    a_valid = 1'b0;
    #1;
    chk("post_rst_occ", occupancy, 1);
    chk("post_rst_ret", resp_ret, 2);
    chk("post_rst_tag", resp_tag, 0);
    resp_ready = 1'b1;
    @(negedge clock); #1;
    chk("post_rst_empty", resp_valid, 0);
    chk("post_rst_occ0", occupancy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
